// File: rtl/sipo16.sv
// sipo16 -- serial-in / parallel-out frame assembler.
//
// Collects N_WORDS words of WORD_W bits from a valid/ready serial stream
// into one parallel frame and presents it on a valid/ready output register.
// The first word received lands in the top word of po, and the last word
// received lands in po[WORD_W-1:0].
//
// A shift register assembles the frame while the output register holds the
// previous frame. If the output register is busy when a frame completes, the
// block parks the frame in the shift register (FULL) and stalls si until the
// consumer frees the slot.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   si        in   serial input word
//   si_valid  in   si carries a word this cycle
//   si_ready  out  block accepts si this cycle (registered-state decode)
//   clr       in   synchronous discard of the partial frame
//   po        out  assembled parallel frame
//   po_valid  out  po holds a complete frame
//   po_ready  in   consumer takes po this cycle
//   word_cnt  out  number of words in the partial frame
module sipo16 #(
  parameter int WORD_W  = 64,
  parameter int N_WORDS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_W-1:0]           si,
  input  logic                        si_valid,
  output logic                        si_ready,
  input  logic                        clr,
  output logic [WORD_W*N_WORDS-1:0]   po,
  output logic                        po_valid,
  input  logic                        po_ready,
  output logic [$clog2(N_WORDS)-1:0]  word_cnt
);

  localparam int FRAME_W = WORD_W * N_WORDS;
  localparam int CNT_W   = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_wordCnt;
  logic [FRAME_W-1:0] r_po;
  logic               r_poValid;

  logic               w_accept;
  logic               w_slotFree;
  logic               w_lastWord;
  logic               w_complete;
  logic               w_loadFromSi;
  logic               w_loadFromShift;
  logic [FRAME_W-1:0] w_shifted;

  // The output slot can take a new frame if it is empty or being consumed
  // on this same edge; that is what lets back-to-back frames run without a
  // stall cycle.
  assign w_accept        = si_valid && (r_state == FILL);
  assign w_slotFree      = !r_poValid || po_ready;
  assign w_lastWord      = (r_wordCnt == LAST_CNT);
  assign w_complete      = w_accept && w_lastWord;
  assign w_shifted       = {r_shift[FRAME_W-WORD_W-1:0], si};
  assign w_loadFromSi    = !clr && w_complete && w_slotFree;
  assign w_loadFromShift = !clr && (r_state == FULL) && w_slotFree;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    w_stateNext = r_state;
    if (clr) begin
      w_stateNext = FILL;
    end else begin
      case (r_state)
        FILL: if (w_complete && !w_slotFree) w_stateNext = FULL;
        FULL: if (w_slotFree)                w_stateNext = FILL;
        default:                             w_stateNext = FILL;
      endcase
    end
  end

  // Output decode: purely from registered state, so si_ready has no
  // combinational path from si_valid or po_ready.
  always_comb begin
    si_ready = (r_state == FILL);
  end

  // Shift register and word counter. On a completing accept with the slot
  // busy the counter parks at N_WORDS-1 until the FULL transfer clears it.
  // The shift register is not cleared after a transfer: the next frame
  // shifts the old contents out completely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_wordCnt <= '0;
    end else if (clr) begin
      r_shift   <= '0;
      r_wordCnt <= '0;
    end else if (w_accept) begin
      r_shift <= w_shifted;
      if (w_lastWord) begin
        if (w_slotFree) r_wordCnt <= '0;
      end else begin
        r_wordCnt <= r_wordCnt + CNT_W'(1);
      end
    end else if (w_loadFromShift) begin
      r_wordCnt <= '0;
    end
  end

  // Output register. clr suppresses loads but a consume on the same edge
  // still empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_po      <= '0;
      r_poValid <= 1'b0;
    end else if (w_loadFromSi) begin
      r_po      <= w_shifted;
      r_poValid <= 1'b1;
    end else if (w_loadFromShift) begin
      r_po      <= r_shift;
      r_poValid <= 1'b1;
    end else if (r_poValid && po_ready) begin
      r_poValid <= 1'b0;
    end
  end

  assign po       = r_po;
  assign po_valid = r_poValid;
  assign word_cnt = r_wordCnt;

endmodule

// File: tb/tb_sipo16.sv
// tb_sipo16 -- scoreboard bench for sipo16 at default parameters.
//
// The stimulus process pushes each frame it expects the DUT to deliver into
// expQ; a monitor pops and compares whenever the DUT presents a frame that
// the consumer takes. Direct checks cover reset values, handshake and
// counter behaviour at the interesting edges.
module tb_sipo16;

  localparam int WORD_W  = 64;
  localparam int N_WORDS = 16;
  localparam int FRAME_W = WORD_W * N_WORDS;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [WORD_W-1:0]  si;
  logic               si_valid;
  logic               si_ready;
  logic               clr;
  logic [FRAME_W-1:0] po;
  logic               po_valid;
  logic               po_ready;
  logic [CNT_W-1:0]   word_cnt;

  logic [FRAME_W-1:0] expQ[$];
  int                 nVectors = 0;
  int                 nMiscompares = 0;

  logic [FRAME_W-1:0] monExp;
  int                 monWord;
  logic [FRAME_W-1:0] piFrame;

  always #5 clk = ~clk;

  sipo16 #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .si       (si),
    .si_valid (si_valid),
    .si_ready (si_ready),
    .clr      (clr),
    .po       (po),
    .po_valid (po_valid),
    .po_ready (po_ready),
    .word_cnt (word_cnt)
  );

  task automatic checkOutput(input string name, input logic [WORD_W-1:0] actual,
                             input logic [WORD_W-1:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame of consecutive words starting at base, first word in the top slot.
  function automatic logic [FRAME_W-1:0] seqFrame(input logic [WORD_W-1:0] base);
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < N_WORDS; i++)
      f[(N_WORDS-1-i)*WORD_W +: WORD_W] = base + WORD_W'(i);
    return f;
  endfunction

  // Offer one word and hold it until accepted. Inputs change 1 time unit
  // after a rising edge; si_ready is a registered decode so it is stable there.
  task automatic applyStimulus(input logic [WORD_W-1:0] w);
    int waitCyc;
    si       = w;
    si_valid = 1'b1;
    waitCyc  = 0;
    while (!si_ready && waitCyc < 64) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (!si_ready) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL accept_timeout: got si_ready=0 for %0d cycles, expected 1", waitCyc);
    end
    @(posedge clk); #1;
    si_valid = 1'b0;
  endtask

  task automatic sendWords(input logic [WORD_W-1:0] base, input int count);
    for (int i = 0; i < count; i++) applyStimulus(base + WORD_W'(i));
  endtask

  // Model of the team PISO: shifts the top word out first.
  task automatic sendPiso(input logic [FRAME_W-1:0] pi);
    for (int i = 0; i < N_WORDS; i++) applyStimulus(pi[(N_WORDS-1-i)*WORD_W +: WORD_W]);
  endtask

  task automatic consumeOne();
    po_ready = 1'b1;
    @(posedge clk); #1;
    po_ready = 1'b0;
  endtask

  // Monitor: a frame is consumed on the edge after a falling edge that sees
  // po_valid && po_ready, so compare it against the scoreboard here.
  always @(negedge clk) begin
    if (rst_n && po_valid && po_ready) begin
      nVectors++;
      if (expQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL unexpected_frame: got top word 0x%0h, expected no frame",
                 po[FRAME_W-1 -: WORD_W]);
      end else begin
        monExp = expQ.pop_front();
        if (po !== monExp) begin
          nMiscompares++;
          monWord = -1;
          for (int i = 0; i < N_WORDS; i++)
            if (monWord < 0 && po[(N_WORDS-1-i)*WORD_W +: WORD_W] !== monExp[(N_WORDS-1-i)*WORD_W +: WORD_W])
              monWord = i;
          $display("[TB] FAIL frame_word%0d: got 0x%0h, expected 0x%0h", monWord,
                   po[(N_WORDS-1-monWord)*WORD_W +: WORD_W],
                   monExp[(N_WORDS-1-monWord)*WORD_W +: WORD_W]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    si = '0; si_valid = 1'b0; clr = 1'b0; po_ready = 1'b0; rst_n = 1'b1;

    // Reset values, checked without a clock edge
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_po_valid", 64'(po_valid), 64'd0);
    checkOutput("reset_po_zero",  64'(|po),      64'd0);
    checkOutput("reset_si_ready", 64'(si_ready), 64'd1);
    checkOutput("reset_word_cnt", 64'(word_cnt), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic fill: words 1..16 with the consumer always ready
    po_ready = 1'b1;
    sendWords(64'd1, 8);
    checkOutput("fill_mid_cnt", 64'(word_cnt), 64'd8);
    sendWords(64'd9, 8);
    expQ.push_back(seqFrame(64'd1));
    checkOutput("fill_po_valid", 64'(po_valid), 64'd1);
    checkOutput("fill_po_top",   po[1023:960],  64'd1);
    checkOutput("fill_po_low",   po[63:0],      64'd16);
    checkOutput("fill_word_cnt", 64'(word_cnt), 64'd0);
    @(posedge clk); #1;
    checkOutput("fill_consumed", 64'(po_valid), 64'd0);

    // Backpressure: A waits in po while B fills and parks in FULL
    po_ready = 1'b0;
    sendWords(64'h100, 16);
    expQ.push_back(seqFrame(64'h100));
    checkOutput("bp_a_valid", 64'(po_valid), 64'd1);
    sendWords(64'h200, 16);
    expQ.push_back(seqFrame(64'h200));
    checkOutput("bp_full_si_ready", 64'(si_ready), 64'd0);
    checkOutput("bp_full_cnt",      64'(word_cnt), 64'd15);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("bp_hold_top",   po[1023:960],  64'h100);
    checkOutput("bp_hold_low",   po[63:0],      64'h10F);
    checkOutput("bp_hold_valid", 64'(po_valid), 64'd1);
    checkOutput("bp_hold_ready", 64'(si_ready), 64'd0);
    consumeOne();
    checkOutput("bp_b_top",      po[1023:960],  64'h200);
    checkOutput("bp_b_low",      po[63:0],      64'h20F);
    checkOutput("bp_b_valid",    64'(po_valid), 64'd1);
    checkOutput("bp_b_si_ready", 64'(si_ready), 64'd1);
    checkOutput("bp_b_cnt",      64'(word_cnt), 64'd0);
    consumeOne();
    checkOutput("bp_b_consumed", 64'(po_valid), 64'd0);

    // Simultaneous edge: last word of B accepted as A is consumed
    sendWords(64'h300, 16);
    expQ.push_back(seqFrame(64'h300));
    sendWords(64'h400, 15);
    checkOutput("sim_cnt15",    64'(word_cnt), 64'd15);
    checkOutput("sim_ready_15", 64'(si_ready), 64'd1);
    po_ready = 1'b1;
    applyStimulus(64'h40F);
    po_ready = 1'b0;
    expQ.push_back(seqFrame(64'h400));
    checkOutput("sim_valid",    64'(po_valid), 64'd1);
    checkOutput("sim_top",      po[1023:960],  64'h400);
    checkOutput("sim_low",      po[63:0],      64'h40F);
    checkOutput("sim_si_ready", 64'(si_ready), 64'd1);
    checkOutput("sim_cnt",      64'(word_cnt), 64'd0);
    consumeOne();

    // clr after 5 words, with a frame pending in po that must survive
    sendWords(64'h500, 16);
    expQ.push_back(seqFrame(64'h500));
    sendWords(64'h11, 5);
    checkOutput("clr_pre_cnt", 64'(word_cnt), 64'd5);
    clr = 1'b1; si = 64'hDEAD; si_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; si_valid = 1'b0;
    checkOutput("clr_cnt",      64'(word_cnt), 64'd0);
    checkOutput("clr_po_valid", 64'(po_valid), 64'd1);
    checkOutput("clr_po_top",   po[1023:960],  64'h500);
    po_ready = 1'b1;
    sendWords(64'h21, 16);
    expQ.push_back(seqFrame(64'h21));
    checkOutput("clr_frame_top", po[1023:960], 64'h21);
    checkOutput("clr_frame_low", po[63:0],     64'h30);
    @(posedge clk); #1;
    checkOutput("clr_consumed", 64'(po_valid), 64'd0);

    // Reset mid-frame with an unconsumed frame in po; both are discarded
    po_ready = 1'b0;
    sendWords(64'h700, 16);
    sendWords(64'h51, 7);
    checkOutput("rst_pre_cnt", 64'(word_cnt), 64'd7);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_po_valid", 64'(po_valid), 64'd0);
    checkOutput("rst_po_zero",  64'(|po),      64'd0);
    checkOutput("rst_si_ready", 64'(si_ready), 64'd1);
    checkOutput("rst_cnt",      64'(word_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    po_ready = 1'b1;
    sendWords(64'h61, 16);
    expQ.push_back(seqFrame(64'h61));
    checkOutput("rst_frame_top", po[1023:960], 64'h61);
    checkOutput("rst_frame_low", po[63:0],     64'h70);

    // Loopback from a modelled PISO with a random frame
    for (int k = 0; k < FRAME_W/32; k++) piFrame[k*32 +: 32] = $urandom;
    sendPiso(piFrame);
    expQ.push_back(piFrame);
    repeat (4) begin @(posedge clk); #1; end
    po_ready = 1'b0;

    checkOutput("all_frames_consumed", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
